adc_serial_ctrl: RTL and testbench

Front-end controller for the 10-bit serial-output ADC (TLC1549-class: CS, I/O clock, DATA OUT) on the measurement board. It sits directly upstream of the top-level processing block `pr_2007` and drives that block's `ad_data_in[9:0]` and `sample_sig` inputs. It runs the chip-select, I/O-clock and conversion-wait sequence continuously while enabled, deserialises each MSB-first frame, and presents every result as a stable parallel word plus a strobe.

---
 rtl/adc_pkg.sv | 25 ++
 rtl/adc_serial_ctrl_if.sv | 34 +++
 rtl/adc_serial_ctrl_sclk_gen.sv | 46 ++++
 rtl/adc_serial_ctrl.sv | 157 +++++++++++++++
 tb/tb_adc_serial_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the serial ADC front end: FSM state encoding,
// result width and the default timing constants.
package adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_CONV
  } adc_state_t;

  localparam int ADC_BITS = 10;

  localparam int DEF_CLK_HALF    = 25;
  localparam int DEF_CS_SETUP    = 70;
  localparam int DEF_CONV_CYCLES = 1100;
  localparam int DEF_HOLD_CYCLES = 25;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/adc_serial_ctrl_if.sv
// Signal bundle between the ADC controller, the ADC pins and the downstream
// processing block; master is the controller side.
interface adc_serial_ctrl_if;
  import adc_pkg::*;

  logic                en;
  logic                adc_dout;
  logic                adc_cs_n;
  logic                adc_sclk;
  logic [ADC_BITS-1:0] ad_data_out;
  logic                sample_sig;
  logic                busy;

  modport master (
    input  en,
    input  adc_dout,
    output adc_cs_n,
    output adc_sclk,
    output ad_data_out,
    output sample_sig,
    output busy
  );

  modport slave (
    output en,
    output adc_dout,
    input  adc_cs_n,
    input  adc_sclk,
    input  ad_data_out,
    input  sample_sig,
    input  busy
  );

endinterface

// File: rtl/adc_serial_ctrl_sclk_gen.sv
// I/O clock generator: CLK_HALF clocks high then CLK_HALF low per period,
// with single-clock pulses on the last clock of each half.
module sclk_gen #(
  parameter int CLK_HALF = 25,
  parameter int CNT_W    = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic start,      // first high half begins on the next edge
  input  logic run,
  input  logic stop,       // suppresses the rise after the current low half
  output logic sclk,
  output logic sample_pt,  // last clock of a high half
  output logic fall_pt     // last clock of a low half (period complete)
);

  logic [CNT_W-1:0] half_cnt_reg;
  logic             sclk_reg;
  logic             half_end;

  assign half_end  = (half_cnt_reg == CNT_W'(CLK_HALF - 1));
  assign sample_pt = run && sclk_reg && half_end;
  assign fall_pt   = run && !sclk_reg && half_end;
  assign sclk      = sclk_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_cnt_reg <= '0;
      sclk_reg     <= 1'b0;
    end else if (start) begin
      half_cnt_reg <= '0;
      sclk_reg     <= 1'b1;
    end else if (run) begin
      if (half_end) begin
        half_cnt_reg <= '0;
        sclk_reg     <= sclk_reg ? 1'b0 : !stop;
      end else begin
        half_cnt_reg <= half_cnt_reg + 1'b1;
      end
    end else begin
      half_cnt_reg <= '0;
      sclk_reg     <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_serial_ctrl.sv
// TLC1549-style serial ADC controller: runs CS / I/O clock / conversion-wait
// frames while enabled and presents each result as a parallel word plus strobe.
module adc_serial_ctrl
  import adc_pkg::*;
#(
  parameter int CLK_HALF    = DEF_CLK_HALF,
  parameter int CS_SETUP    = DEF_CS_SETUP,
  parameter int CONV_CYCLES = DEF_CONV_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input logic               clk,
  input logic               rst,
  adc_serial_ctrl_if.master bus
);

  localparam int CNT_W  = $clog2(max3(CS_SETUP, CONV_CYCLES, CLK_HALF) + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [3:0] LAST_BIT = 4'(ADC_BITS - 1);

  adc_state_t          state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [3:0]          bit_cnt_reg;
  logic [ADC_BITS-1:0] shift_reg;
  logic [ADC_BITS-1:0] data_reg;
  logic [HOLD_W-1:0]   hold_cnt_reg;
  logic [1:0]          sync_reg;
  logic                cs_n_reg;
  logic                sample_reg;
  logic                busy_reg;
  logic                first_reg;

  logic setup_done;
  logic in_shift;
  logic last_bit;
  logic sclk;
  logic sample_pt;
  logic fall_pt;

  assign setup_done = (state_reg == ST_SETUP) && (cnt_reg == CNT_W'(CS_SETUP - 1));
  assign in_shift   = (state_reg == ST_SHIFT);
  assign last_bit   = (bit_cnt_reg == LAST_BIT);

  sclk_gen #(
    .CLK_HALF (CLK_HALF),
    .CNT_W    (CNT_W)
  ) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .start     (setup_done),
    .run       (in_shift),
    .stop      (last_bit),
    .sclk      (sclk),
    .sample_pt (sample_pt),
    .fall_pt   (fall_pt)
  );

  // adc_dout is asynchronous to clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], bus.adc_dout};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      data_reg     <= '0;
      hold_cnt_reg <= '0;
      cs_n_reg     <= 1'b1;
      sample_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      first_reg    <= 1'b1;
    end else begin
      if (sample_reg) begin
        if (hold_cnt_reg == HOLD_W'(HOLD_CYCLES - 1)) begin
          sample_reg   <= 1'b0;
          hold_cnt_reg <= '0;
        end else begin
          hold_cnt_reg <= hold_cnt_reg + 1'b1;
        end
      end

      case (state_reg)
        ST_IDLE: begin
          if (bus.en) begin
            state_reg <= ST_SETUP;
            cs_n_reg  <= 1'b0;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
          end
        end

        ST_SETUP: begin
          if (setup_done) begin
            state_reg   <= ST_SHIFT;
            bit_cnt_reg <= '0;
            cnt_reg     <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        ST_SHIFT: begin
          if (sample_pt) begin
            shift_reg <= {shift_reg[ADC_BITS-2:0], sync_reg[1]};
          end
          if (fall_pt) begin
            if (last_bit) begin
              state_reg <= ST_CONV;
              cs_n_reg  <= 1'b1;
              cnt_reg   <= '0;
              first_reg <= 1'b0;
              // The first frame of a run carries a stale conversion
              if (!first_reg) begin
                data_reg     <= shift_reg;
                sample_reg   <= 1'b1;
                hold_cnt_reg <= '0;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
        end

        ST_CONV: begin
          if (cnt_reg == CNT_W'(CONV_CYCLES - 1)) begin
            cnt_reg <= '0;
            if (bus.en) begin
              state_reg <= ST_SETUP;
              cs_n_reg  <= 1'b0;
            end else begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
              first_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.adc_cs_n    = cs_n_reg;
  assign bus.adc_sclk    = sclk;
  assign bus.ad_data_out = data_reg;
  assign bus.sample_sig  = sample_reg;
  assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_adc_serial_ctrl.sv
// Bench for adc_serial_ctrl: default-timing and minimum-timing instances, each
// fed by a behavioural ADC model, with a scoreboard of expected results.
module tb_adc_serial_ctrl;
  import adc_pkg::*;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  logic [ADC_BITS-1:0] words_q [2][$];
  logic [ADC_BITS-1:0] exp_a [$];
  logic [ADC_BITS-1:0] exp_b [$];

  adc_serial_ctrl_if bus_if [2] ();

  adc_serial_ctrl dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_if[0])
  );

  adc_serial_ctrl #(
    .CLK_HALF    (2),
    .CS_SETUP    (2),
    .CONV_CYCLES (1),
    .HOLD_CYCLES (1)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_if[1])
  );

  always #5 clk = ~clk;

  // ADC model plus recorder, one per instance
  for (genvar gi = 0; gi < 2; gi++) begin : g_mon
    int                  cyc = 0;
    int                  widx = 0;
    int                  bitidx = -1;
    logic [ADC_BITS-1:0] word = '0;
    logic                prev_cs = 1'b1;
    logic                prev_sclk = 1'b0;
    logic                prev_sample = 1'b0;
    logic [ADC_BITS-1:0] prev_data = '0;
    logic                lo_act = 1'b0;
    int                  hi_len = 0;
    int                  lo_len = 0;
    int                  rises = 0;
    int                  pulse_len = 0;
    int                  stray = 0;
    int                  res_q [$];
    int                  res_t_q [$];
    int                  width_q [$];
    int                  cs_fall_q [$];
    int                  cs_rise_q [$];
    int                  rise_cnt_q [$];
    int                  hi_q [$];
    int                  lo_q [$];

    always @(negedge clk) begin
      logic cs;
      logic s;
      logic smp;
      logic rs;
      logic [ADC_BITS-1:0] d;
      cyc++;
      cs  = bus_if[gi].adc_cs_n;
      s   = bus_if[gi].adc_sclk;
      smp = bus_if[gi].sample_sig;
      d   = bus_if[gi].ad_data_out;
      if (gi == 0) rs = rst_a;
      else         rs = rst_b;

      if (prev_cs && !cs) begin
        word = (widx < words_q[gi].size()) ? words_q[gi][widx] : '0;
        widx++;
        bitidx = ADC_BITS - 1;
        bus_if[gi].adc_dout = word[bitidx];
      end else if (!cs && prev_sclk && !s) begin
        bitidx--;
        if (bitidx >= 0) bus_if[gi].adc_dout = word[bitidx];
      end

      if (s && !prev_sclk) begin
        if (lo_act) lo_q.push_back(lo_len);
        lo_act = 1'b0;
        hi_len = 0;
        rises++;
      end
      if (!s && prev_sclk) begin
        hi_q.push_back(hi_len);
        lo_act = 1'b1;
        lo_len = 0;
      end
      if (cs && !prev_cs) begin
        if (lo_act) lo_q.push_back(lo_len);
        lo_act = 1'b0;
        rise_cnt_q.push_back(rises);
        cs_rise_q.push_back(cyc);
      end
      if (!cs && prev_cs) begin
        cs_fall_q.push_back(cyc);
        rises = 0;
      end
      if (s) hi_len++;
      if (lo_act && !s) lo_len++;

      if (smp && !prev_sample) begin
        res_q.push_back(int'(d));
        res_t_q.push_back(cyc);
        pulse_len = 0;
      end
      if (smp) pulse_len++;
      if (!smp && prev_sample) width_q.push_back(pulse_len);
      if ((d != prev_data) && !(smp && !prev_sample) && !rs) stray++;

      prev_cs     = cs;
      prev_sclk   = s;
      prev_sample = smp;
      prev_data   = d;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int count_of(input int kind, input int gi);
    case (kind)
      0:       return (gi == 0) ? g_mon[0].res_q.size()     : g_mon[1].res_q.size();
      1:       return (gi == 0) ? g_mon[0].cs_fall_q.size() : g_mon[1].cs_fall_q.size();
      default: return (gi == 0) ? g_mon[0].cs_rise_q.size() : g_mon[1].cs_rise_q.size();
    endcase
  endfunction

  // kind: 0 results, 1 cs falls, 2 cs rises
  task automatic wait_count(input int kind, input int gi, input int n, input int budget);
    int c;
    c = 0;
    while ((count_of(kind, gi) < n) && (c < budget)) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk($sformatf("wait_k%0d_g%0d_n%0d", kind, gi, n), 32'(count_of(kind, gi) >= n), 32'd1);
  endtask

  task automatic push_word(input int gi, input logic [ADC_BITS-1:0] w, input bit expected);
    words_q[gi].push_back(w);
    if (expected) begin
      if (gi == 0) exp_a.push_back(w);
      else         exp_b.push_back(w);
    end
  endtask

  initial begin
    int r0;
    int bad_hi;
    int bad_lo;

    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_if[0].en = 1'b0;
    bus_if[1].en = 1'b0;

    push_word(0, 10'h1C3, 0);
    push_word(0, 10'h2A5, 1);
    push_word(0, 10'h15A, 1);
    push_word(0, 10'h3FF, 1);
    push_word(0, 10'h000, 1);
    push_word(0, 10'h0F0, 1);
    push_word(0, 10'h222, 0);
    push_word(0, 10'h0CC, 1);
    push_word(0, 10'h333, 0);
    push_word(0, 10'h111, 0);
    push_word(0, 10'h1EE, 1);
    push_word(1, 10'h0AA, 0);
    push_word(1, 10'h2A5, 1);
    push_word(1, 10'h3FF, 1);
    push_word(1, 10'h000, 1);
    push_word(1, 10'h155, 1);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_cs_n",   bus_if[0].adc_cs_n,    1);
    chk("rst_sclk",   bus_if[0].adc_sclk,    0);
    chk("rst_data",   bus_if[0].ad_data_out, 0);
    chk("rst_sample", bus_if[0].sample_sig,  0);
    chk("rst_busy",   bus_if[0].busy,        0);
    chk("rst_b_cs_n", bus_if[1].adc_cs_n,    1);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_if[0].en = 1'b1;
    bus_if[1].en = 1'b1;

    // Minimum-timing instance
    wait_count(0, 1, 4, 1000);
    repeat (3) @(negedge clk);
    bus_if[1].en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b_data%0d", i),  g_mon[1].res_q[i], 32'(exp_b.pop_front()));
      chk($sformatf("b_width%0d", i), g_mon[1].width_q[i], 1);
    end
    for (int i = 0; i < 3; i++)
      chk($sformatf("b_period%0d", i), g_mon[1].cs_fall_q[i+1] - g_mon[1].cs_fall_q[i], 43);
    for (int i = 0; i < 4; i++)
      chk($sformatf("b_rises%0d", i), g_mon[1].rise_cnt_q[i], 10);
    chk("b_load_time", g_mon[1].res_t_q[0] - g_mon[1].cs_fall_q[0], 85);
    bad_hi = 0;
    bad_lo = 0;
    for (int i = 0; i < 40; i++) begin
      if (g_mon[1].hi_q[i] != 2) bad_hi++;
      if (g_mon[1].lo_q[i] != 2) bad_lo++;
    end
    chk("b_sclk_high_bad", bad_hi, 0);
    chk("b_sclk_low_bad",  bad_lo, 0);

    // Default instance: continuous run, then en dropped inside frame 6's SHIFT
    wait_count(0, 0, 4, 7 * 1700);
    wait_count(1, 0, 6, 2000);
    repeat (200) @(negedge clk);
    #1;
    chk("a_busy_shift", bus_if[0].busy, 1);
    bus_if[0].en = 1'b0;
    wait_count(0, 0, 5, 2000);
    repeat (3000) @(negedge clk);
    #1;
    chk("a_idle_cs_n",  bus_if[0].adc_cs_n, 1);
    chk("a_idle_busy",  bus_if[0].busy,     0);
    chk("a_idle_falls", count_of(1, 0),     6);

    // Re-enable: one discarded frame, then a result; then reset mid-SHIFT
    bus_if[0].en = 1'b1;
    wait_count(0, 0, 6, 2 * 1700 + 200);
    wait_count(1, 0, 9, 2000);
    repeat (200) @(negedge clk);
    #2;
    rst_a = 1'b1;
    #1;
    chk("mid_rst_cs_n",   bus_if[0].adc_cs_n,    1);
    chk("mid_rst_sclk",   bus_if[0].adc_sclk,    0);
    chk("mid_rst_data",   bus_if[0].ad_data_out, 0);
    chk("mid_rst_sample", bus_if[0].sample_sig,  0);
    chk("mid_rst_busy",   bus_if[0].busy,        0);
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    r0 = count_of(2, 0);
    wait_count(2, 0, r0 + 1, 2000);
    chk("post_rst_data",   bus_if[0].ad_data_out, 0);
    chk("post_rst_sample", bus_if[0].sample_sig,  0);
    wait_count(0, 0, 7, 2000);
    repeat (30) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      chk($sformatf("a_data%0d", i),  g_mon[0].res_q[i], 32'(exp_a.pop_front()));
      chk($sformatf("a_width%0d", i), g_mon[0].width_q[i], 25);
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("a_period%0d", i), g_mon[0].cs_fall_q[i+1] - g_mon[0].cs_fall_q[i], 1670);
    for (int i = 0; i < 5; i++)
      chk($sformatf("a_rises%0d", i), g_mon[0].rise_cnt_q[i], 10);
    chk("a_load_time", g_mon[0].res_t_q[0] - g_mon[0].cs_fall_q[0], 2240);
    bad_hi = 0;
    bad_lo = 0;
    for (int i = 0; i < 50; i++) begin
      if (g_mon[0].hi_q[i] != 25) bad_hi++;
      if (g_mon[0].lo_q[i] != 25) bad_lo++;
    end
    chk("a_sclk_high_bad", bad_hi, 0);
    chk("a_sclk_low_bad",  bad_lo, 0);
    chk("a_data_stray",    g_mon[0].stray, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
